// File: rtl/key_click_decoder.sv
// Multi-click decoder: groups debounced key-press strobes into click sequences separated
// by a gap window and reports the click count of each completed sequence.
module key_click_decoder #(
  parameter int CLK_FREQ_MHZ = 150,
  parameter int WINDOW_US    = 300,
  parameter int MAX_CLICKS   = 3,
  localparam int WINDOW_CYCLES = CLK_FREQ_MHZ * WINDOW_US,
  localparam int CW            = $clog2(MAX_CLICKS + 1),
  localparam int TW            = $clog2(WINDOW_CYCLES + 1)
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          key_pressed_stb_i,
  output logic [CW-1:0] click_cnt_o,
  output logic          click_valid_o,
  output logic          busy_o
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_e;

  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_CLICKS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(WINDOW_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_out_q, cnt_out_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;

  // Next-state logic; a strobe always beats the timeout on the same edge.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timer_d   = timer_q;
    cnt_out_d = cnt_out_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_pressed_stb_i) begin
          if (CW'(1) == MAX_CNT) begin
            valid_d   = 1'b1;
            cnt_out_d = MAX_CNT;
          end else begin
            state_d = COUNT;
            count_d = CW'(1);
            timer_d = '0;
          end
        end else begin
          count_d = '0;
          timer_d = '0;
        end
      end
      COUNT: begin
        if (key_pressed_stb_i) begin
          if (count_q + CW'(1) == MAX_CNT) begin
            valid_d   = 1'b1;
            cnt_out_d = MAX_CNT;
            state_d   = IDLE;
            count_d   = '0;
            timer_d   = '0;
          end else begin
            count_d = count_q + CW'(1);
            timer_d = '0;
          end
        end else if (timer_q == TIMER_LAST) begin
          // Window has elapsed without a new click: close the sequence.
          valid_d   = 1'b1;
          cnt_out_d = count_q;
          state_d   = IDLE;
          count_d   = '0;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        timer_d = '0;
      end
    endcase
    busy_d = (state_d == COUNT);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      timer_q   <= '0;
      cnt_out_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      cnt_out_q <= cnt_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign click_cnt_o   = cnt_out_q;
  assign click_valid_o = valid_q;
  assign busy_o        = busy_q;

endmodule
